// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared types, defaults and helpers for the serial front end
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int   DEFAULT_WIDTH     = 8;
  localparam logic SERIAL_IDLE_LEVEL = 1'b1;

  // First bit to leave a word of the given width for the chosen bit order.
  function automatic logic lead_bit(input logic [31:0] word, input int width, input bit msb_first);
    return msb_first ? word[width-1] : word[0];
  endfunction

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// rtl/bit_serializer_bit_counter.sv - modulo-WIDTH up-counter with clear, enable and last flag
module bit_counter
  import bit_serializer_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt     = cnt_q;
  assign at_last = (cnt_q == CW'(WIDTH - 1));

  // Clear wins over enable so a reload on the last count restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end feeding the serial pattern detector
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = SERIAL_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;

  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             cnt_clear;
  logic             cnt_en;
  logic             xfer;
  logic [WIDTH-1:0] sr_shift;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .rst     (reset),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .cnt     (cnt),
    .at_last (at_last)
  );

  assign din_ready = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && at_last);
  assign xfer      = din_valid && din_ready;
  assign sr_shift  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;

  // x_q always mirrors the outgoing end of the next shift register value.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d       = IDLE_LEVEL;
        x_valid_d = 1'b0;
        if (xfer) begin
          state_d   = ST_SHIFT;
          sr_d      = din;
          x_d       = lead_bit(32'(din), WIDTH, MSB_FIRST);
          x_valid_d = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (at_last) begin
          cnt_clear = 1'b1;
          if (xfer) begin
            sr_d      = din;
            x_d       = lead_bit(32'(din), WIDTH, MSB_FIRST);
            x_valid_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            x_d       = IDLE_LEVEL;
            x_valid_d = 1'b0;
          end
        end else begin
          cnt_en    = 1'b1;
          sr_d      = sr_shift;
          x_d       = lead_bit(32'(sr_shift), WIDTH, MSB_FIRST);
          x_valid_d = 1'b1;
          done_d    = (cnt == CW'(WIDTH - 2));
        end
      end
      default: begin
        state_d   = ST_IDLE;
        x_d       = IDLE_LEVEL;
        x_valid_d = 1'b0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      x_q       <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - randomized bench against a queue-of-bits reference model
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;

  logic din_ready_m, x_m, x_valid_m, busy_m, done_m;
  logic din_ready_l, x_l, x_valid_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  bit q_m[$];
  bit q_l[$];

  logic [31:0] col_m, col_l;
  int          nv;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_m),
    .x         (x_m),
    .x_valid   (x_valid_m),
    .busy      (busy_m),
    .done      (done_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_l),
    .x         (x_l),
    .x_valid   (x_valid_l),
    .busy      (busy_l),
    .done      (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue holds the bits still to appear on x; head is the bit on x now.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_m.delete();
      q_l.delete();
    end else begin
      int sz;
      sz = q_m.size();
      if (sz > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (sz <= 1 && din_valid === 1'b1) begin
        for (int i = 0; i < 8; i++) begin
          q_m.push_back(din[7-i]);
          q_l.push_back(din[i]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    int sm, sl;
    sm = q_m.size();
    sl = q_l.size();
    check("x_m",         32'(x_m),         32'((sm > 0) ? q_m[0] : 1'b1));
    check("x_valid_m",   32'(x_valid_m),   32'(sm > 0));
    check("busy_m",      32'(busy_m),      32'(sm > 0));
    check("done_m",      32'(done_m),      32'(sm == 1));
    check("din_ready_m", 32'(din_ready_m), 32'(sm <= 1));
    check("x_l",         32'(x_l),         32'((sl > 0) ? q_l[0] : 1'b1));
    check("x_valid_l",   32'(x_valid_l),   32'(sl > 0));
    check("done_l",      32'(done_l),      32'(sl == 1));
    check("din_ready_l", 32'(din_ready_l), 32'(sl <= 1));
    if (x_valid_m === 1'b1) begin
      col_m = {col_m[30:0], x_m};
      nv++;
    end
    if (x_valid_l === 1'b1) col_l = {col_l[30:0], x_l};
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    din_valid = v;
    din       = d;
    @(negedge clk);
    compare_all();
  endtask

  task automatic start_capture();
    col_m = '0;
    col_l = '0;
    nv    = 0;
  endtask

  task automatic mid_cycle_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_async_x",       32'(x_m),       32'h1);
    check("rst_async_x_valid", 32'(x_valid_m), 32'h0);
    check("rst_async_busy",    32'(busy_m),    32'h0);
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    start_capture();
    repeat (3) step(1'b0, 8'h00);
    reset = 1'b0;

    step(1'b1, 8'h81);
    repeat (2) step(1'b0, 8'h00);
    mid_cycle_reset();
    repeat (20) step(1'b0, 8'h00);

    start_capture();
    step(1'b1, 8'h66);
    repeat (9) step(1'b0, 8'h00);
    check("w66_msb", col_m, 32'h66);
    check("w66_lsb", col_l, 32'h66);
    check("w66_nbits", 32'(nv), 32'd8);

    start_capture();
    step(1'b1, 8'hA5);
    repeat (8) step(1'b1, 8'h3C);
    repeat (9) step(1'b0, 8'h00);
    check("b2b_msb", col_m, 32'hA53C);
    check("b2b_nbits", 32'(nv), 32'd16);

    start_capture();
    step(1'b1, 8'h06);
    repeat (9) step(1'b0, 8'h00);
    check("w06_lsb", col_l, 32'h60);
    check("w06_msb", col_m, 32'h06);

    step(1'b1, 8'hFF);
    repeat (2) step(1'b0, 8'h00);
    mid_cycle_reset();
    start_capture();
    step(1'b1, 8'h00);
    repeat (9) step(1'b0, 8'h00);
    check("after_rst_bits", col_m, 32'h0);
    check("after_rst_nbits", 32'(nv), 32'd8);

    start_capture();
    step(1'b1, 8'hC3);
    repeat (2) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    repeat (7) step(1'b0, 8'h00);
    check("no_spurious_bits", col_m, 32'hC3);
    check("no_spurious_nbits", 32'(nv), 32'd8);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = (i % 97 < 40) ? 8'h5B : 8'($urandom);
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, d);
      if ($urandom_range(0, 79) == 0) mid_cycle_reset();
    end
    repeat (10) step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
